// File: rtl/fbuff_arb_pkg.sv
// fbuff_arb_pkg: shared FSM state type and FIFO sizing helper for the frame buffer arbiter.
package fbuff_arb_pkg;
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR} arb_state_t;

    // Level width needs one extra bit so a full FIFO is distinguishable from empty;
    // an illegal depth collapses to zero width so elaboration trips over it.
    function automatic int lvl_width(input int depth);
        return (depth >= 2 && (depth & (depth - 1)) == 0) ? $clog2(depth) + 1 : 0;
    endfunction
endpackage

// File: rtl/fbuff_wr_fifo.sv
// fbuff_wr_fifo: host write FIFO of {addr, data} with extra-bit pointers.
module fbuff_wr_fifo import fbuff_arb_pkg::*; #(
    parameter int AW    = 13,
    parameter int DW    = 48,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int LW   = lvl_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);
    logic [AW+DW-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign level   = wr_ptr - rd_ptr;
    assign full    = level == LW'(DEPTH);
    assign empty   = wr_ptr == rd_ptr;
    assign {head_addr, head_data} = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + (PW+1)'(do_push);
            rd_ptr <= rd_ptr + (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= {push_addr, push_data};
    end
endmodule

// File: rtl/fbuff_arbiter.sv
// fbuff_arbiter: shares the single-port frame buffer between line-buffer reads (priority)
// and buffered host writes, with a read burst limit so pending writes always progress.
module fbuff_arbiter import fbuff_arb_pkg::*; #(
    parameter int FBUFF_ADDR_WIDTH = 13,
    parameter int FBUFF_DATA_WIDTH = 48,
    parameter int WR_FIFO_DEPTH    = 4,
    parameter int MAX_RD_BURST     = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              lb_rd_req_i,
    input  logic [FBUFF_ADDR_WIDTH-1:0]       lb_addr_i,
    output logic                              lb_rd_rsp_o,
    output logic [FBUFF_DATA_WIDTH-1:0]       lb_data_o,
    input  logic                              host_wr_valid_i,
    output logic                              host_wr_ready_o,
    input  logic [FBUFF_ADDR_WIDTH-1:0]       host_addr_i,
    input  logic [FBUFF_DATA_WIDTH-1:0]       host_data_i,
    output logic                              fbuff_en_o,
    output logic                              fbuff_wea_o,
    output logic [FBUFF_ADDR_WIDTH-1:0]       fbuff_addra_o,
    output logic [FBUFF_DATA_WIDTH-1:0]       fbuff_dina_o,
    output logic                              fbuff_rd_req_o,
    input  logic                              fbuff_rd_rsp_i,
    input  logic [FBUFF_DATA_WIDTH-1:0]       fbuff_douta_i,
    output logic [lvl_width(WR_FIFO_DEPTH)-1:0] wr_fifo_lvl_o
);
    localparam int BW = $clog2(MAX_RD_BURST + 1);

    arb_state_t                  state;
    logic [BW-1:0]               burst_cnt;
    logic                        rdy, full, empty, push, rd_grant, wr_grant;
    logic [FBUFF_ADDR_WIDTH-1:0] head_addr;
    logic [FBUFF_DATA_WIDTH-1:0] head_data;

    // rdy holds ready low through reset and rises on the first edge after release
    assign host_wr_ready_o = rdy & ~full;
    assign push            = host_wr_valid_i & host_wr_ready_o;
    assign rd_grant        = state == IDLE && lb_rd_req_i && (empty || burst_cnt < BW'(MAX_RD_BURST));
    assign wr_grant        = state == IDLE && !rd_grant && !empty;
    assign lb_rd_rsp_o     = fbuff_rd_rsp_i && state == RD_WAIT;
    assign lb_data_o       = fbuff_douta_i;

    fbuff_wr_fifo #(
        .AW(FBUFF_ADDR_WIDTH), .DW(FBUFF_DATA_WIDTH), .DEPTH(WR_FIFO_DEPTH)
    ) u_fifo (
        .clk(clk_i), .rst(rst_i), .push(push), .pop(wr_grant),
        .push_addr(host_addr_i), .push_data(host_data_i),
        .head_addr(head_addr), .head_data(head_data),
        .full(full), .empty(empty), .level(wr_fifo_lvl_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            rdy            <= 1'b0;
            burst_cnt      <= '0;
            fbuff_en_o     <= 1'b0;
            fbuff_wea_o    <= 1'b0;
            fbuff_rd_req_o <= 1'b0;
            fbuff_addra_o  <= '0;
            fbuff_dina_o   <= '0;
        end else begin
            rdy            <= 1'b1;
            burst_cnt      <= (empty || wr_grant) ? '0 :
                              (rd_grant && burst_cnt < BW'(MAX_RD_BURST)) ? burst_cnt + 1'b1 : burst_cnt;
            fbuff_rd_req_o <= rd_grant;
            fbuff_wea_o    <= wr_grant;
            case (state)
                IDLE: begin
                    fbuff_en_o <= rd_grant | wr_grant;
                    if (rd_grant) begin
                        fbuff_addra_o <= lb_addr_i;
                        state         <= RD_WAIT;
                    end else if (wr_grant) begin
                        fbuff_addra_o <= head_addr;
                        fbuff_dina_o  <= head_data;
                        state         <= WR;
                    end
                end
                RD_WAIT: if (fbuff_rd_rsp_i) begin
                    fbuff_en_o <= 1'b0;
                    state      <= IDLE;
                end
                WR: begin
                    fbuff_en_o <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
